// File: rtl/boardman_v3_bus_arbiter_pkg.sv
// Shared types and helpers for the multi-channel board-manager bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package boardman_v3_bus_arbiter_pkg;

  // Arbiter FSM encodings; numeric values are fixed so waveforms stay comparable across revisions
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Read data handed back to a requester whose slave never acknowledged
  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hFFFF_FFFF;

  // Channel index width; a single channel still needs one bit
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Timeout counter width; kept at one bit when the timeout is disabled
  function automatic int cnt_bits(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/boardman_v3_rr_pick.sv
// Round-robin picker: first requester after the last-granted channel, with wrap.
// Latency: purely combinational.
// Backpressure: none; caller decides when to act on o_vld.
module boardman_v3_rr_pick
  import boardman_v3_bus_arbiter_pkg::*;
#(
  parameter int  NUM_CH  = 2,
  localparam int CH_BITS = ch_bits(NUM_CH)
) (
  input  logic [NUM_CH-1:0]  i_req,
  input  logic [CH_BITS-1:0] i_last,
  output logic               o_vld,
  output logic [CH_BITS-1:0] o_idx
);

  // Scan farthest offset first so the nearest requester after i_last is written last and wins
  always_comb begin
    int                 v_c;
    logic [CH_BITS-1:0] v_idx;
    v_c   = 0;
    v_idx = '0;
    o_vld = 1'b0;
    o_idx = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      v_c   = (int'(i_last) + off) % NUM_CH;
      v_idx = CH_BITS'(v_c);
      if (i_req[v_idx]) begin
        o_vld = 1'b1;
        o_idx = v_idx;
      end
    end
  end

endmodule

// File: rtl/boardman_v3_bus_arbiter.sv
// Shares one register-bus master among NUM_CH board-manager links, round-robin, one transaction at a time.
// Latency: en_o one clock after grant; s_ack_o one clock after ack_i (or after the timeout expires).
// Backpressure: requesters hold s_en_i until s_ack_o; a silent slave is cut off after TIMEOUT_CYCLES.
module boardman_v3_bus_arbiter
  import boardman_v3_bus_arbiter_pkg::*;
#(
  parameter int          NUM_CH         = 2,
  parameter int          ADR_BITS       = 20,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = DEFAULT_TIMEOUT_DATA,
  localparam int         CH_BITS        = ch_bits(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*ADR_BITS-1:0] s_adr_i,
  input  logic [NUM_CH*32-1:0]       s_dat_i,
  input  logic [NUM_CH-1:0]          s_en_i,
  input  logic [NUM_CH-1:0]          s_wr_i,
  input  logic [NUM_CH*4-1:0]        s_wstrb_i,
  output logic [NUM_CH-1:0]          s_ack_o,
  output logic [NUM_CH-1:0]          s_err_o,
  output logic [31:0]                s_dat_o,
  output logic [ADR_BITS-1:0]        adr_o,
  output logic [31:0]                dat_o,
  input  logic [31:0]                dat_i,
  output logic                       en_o,
  output logic                       wr_o,
  output logic [3:0]                 wstrb_o,
  input  logic                       ack_i,
  output logic [CH_BITS-1:0]         grant_o,
  output logic [7:0]                 timeout_cnt_o
);

  localparam int              TO_W    = cnt_bits(TIMEOUT_CYCLES);
  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state, w_state_nxt;
  logic [CH_BITS-1:0]  r_last, r_grant, w_pick_idx;
  logic                w_pick_vld;
  logic [ADR_BITS-1:0] r_adr, w_sel_adr;
  logic [31:0]         r_dat, w_sel_dat, r_sdat;
  logic                r_wr, w_sel_wr, r_en;
  logic [3:0]          r_wstrb, w_sel_wstrb;
  logic [NUM_CH-1:0]   r_ack, r_err;
  logic [TO_W-1:0]     r_tcnt;
  logic [7:0]          r_tocnt;
  logic                w_tmo_hit, w_load, w_done_ok, w_done_tmo;

  boardman_v3_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .i_req  (s_en_i),
    .i_last (r_last),
    .o_vld  (w_pick_vld),
    .o_idx  (w_pick_idx)
  );

  assign w_tmo_hit = TO_EN && (r_tcnt == TO_LAST);

  // Mux the picked channel's request fields out of the flattened buses
  always_comb begin
    w_sel_adr   = '0;
    w_sel_dat   = '0;
    w_sel_wr    = 1'b0;
    w_sel_wstrb = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_pick_idx == CH_BITS'(k)) begin
        w_sel_adr   = s_adr_i[k*ADR_BITS +: ADR_BITS];
        w_sel_dat   = s_dat_i[k*32 +: 32];
        w_sel_wr    = s_wr_i[k];
        w_sel_wstrb = s_wstrb_i[k*4 +: 4];
      end
    end
  end

  // Next-state and control strobes; ack takes priority over a coincident timeout
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done_ok   = 1'b0;
    w_done_tmo  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_load      = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (ack_i) begin
          w_done_ok   = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_tmo_hit) begin
          w_done_tmo  = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Bus datapath, completion pulses and timeout bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last  <= CH_BITS'(NUM_CH - 1);
      r_grant <= '0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_wr    <= 1'b0;
      r_wstrb <= '0;
      r_en    <= 1'b0;
      r_ack   <= '0;
      r_err   <= '0;
      r_sdat  <= '0;
      r_tcnt  <= '0;
      r_tocnt <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      if (w_load) begin
        r_adr   <= w_sel_adr;
        r_dat   <= w_sel_dat;
        r_wr    <= w_sel_wr;
        r_wstrb <= w_sel_wstrb;
        r_grant <= w_pick_idx;
        r_last  <= w_pick_idx;
        r_en    <= 1'b1;
        r_tcnt  <= '0;
      end
      if (w_done_ok) begin
        r_en           <= 1'b0;
        r_ack[r_grant] <= 1'b1;
        r_sdat         <= dat_i;
      end
      if (w_done_tmo) begin
        r_en           <= 1'b0;
        r_ack[r_grant] <= 1'b1;
        r_err[r_grant] <= 1'b1;
        r_sdat         <= TIMEOUT_DATA;
        if (r_tocnt != 8'hFF) r_tocnt <= r_tocnt + 8'd1;
      end
      if (TO_EN && (r_state == ST_BUSY) && !ack_i && !w_tmo_hit) r_tcnt <= r_tcnt + TO_W'(1);
    end
  end

  assign s_ack_o       = r_ack;
  assign s_err_o       = r_err;
  assign s_dat_o       = r_sdat;
  assign adr_o         = r_adr;
  assign dat_o         = r_dat;
  assign en_o          = r_en;
  assign wr_o          = r_wr;
  assign wstrb_o       = r_wstrb;
  assign grant_o       = r_grant;
  assign timeout_cnt_o = r_tocnt;

endmodule
